ifetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the program counter and issues word requests to instruction memory. Returned words are held in a small in-order buffer, and the block presents one registered instruction per cycle together with its PC and PC+4. Branch and jump redirects come from the execute stage; a redirect discards all in-flight and buffered wrong-path fetches.

---
 rtl/ifetch_unit.sv | 135 +++++++++++++
 tb/tb_ifetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers returned words
// in order and presents one registered instruction per cycle to the decoder.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o,
   output logic        inst_valid_o
);
   localparam int unsigned PW    = $clog2(BUF_DEPTH);
   localparam int unsigned CW    = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

   logic [31:0]   buf_inst_q [BUF_DEPTH];
   logic [31:0]   buf_pc_q   [BUF_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
   logic [31:0]   inst_q, inst_d, pc_q, pc_d, pc4_q, pc4_d;
   logic          valid_q, valid_d;

   logic          grant, push, pop;
   logic [CW-1:0] count_pushed;
   logic [31:0]   head_inst, head_pc, target;

   assign imem_req_o   = rst_i & ~redirect_i & (({1'b0, out_q} + {1'b0, count_q}) < DEPTH);
   assign imem_addr_o  = fetch_pc_q;
   assign grant        = imem_req_o & imem_gnt_i;
   assign push         = imem_rvalid_i & ~redirect_i & (drop_q == '0);
   assign count_pushed = count_q + CW'(push);
   assign pop          = ~redirect_i & ~stall_i & (count_pushed != '0);
   // Empty buffer: the word arriving this cycle bypasses straight to the output.
   assign head_inst    = (count_q != '0) ? buf_inst_q[head_q] : imem_rdata_i;
   assign head_pc      = (count_q != '0) ? buf_pc_q[head_q]   : resp_pc_q;
   assign target       = {redirect_pc_i[31:2], 2'b00};

   assign inst_o       = inst_q;
   assign pc_o         = pc_q;
   assign pcPlus4_o    = pc4_q;
   assign inst_valid_o = valid_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_pushed - CW'(pop);
      out_d      = out_q + CW'(grant) - CW'(imem_rvalid_i);
      drop_d     = drop_q;
      inst_d     = inst_q;
      pc_d       = pc_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;

      if (grant)
         fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rvalid_i && (drop_q != '0))
         drop_d = drop_q - CW'(1);
      if (push) begin
         resp_pc_d = resp_pc_q + 32'd4;
         tail_d    = tail_q + PW'(1);
      end
      if (pop) begin
         head_d  = head_q + PW'(1);
         inst_d  = head_inst;
         pc_d    = head_pc;
         pc4_d   = head_pc + 32'd4;
         valid_d = 1'b1;
      end else if (!stall_i) begin
         inst_d  = NOP_INST;
         valid_d = 1'b0;
      end

      // Everything still in flight belongs to the old path and must be dropped.
      if (redirect_i) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         drop_d     = out_d;
         inst_d     = NOP_INST;
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         out_q      <= '0;
         drop_q     <= '0;
         inst_q     <= NOP_INST;
         pc_q       <= RESET_PC;
         pc4_q      <= RESET_PC + 32'd4;
         valid_q    <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         inst_q     <= inst_d;
         pc_q       <= pc_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i && push) begin
         buf_inst_q[tail_q] <= imem_rdata_i;
         buf_pc_q[tail_q]   <= resp_pc_q;
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model with tagged requests and a
// program-order reference of the instruction stream the decoder should see.
module tb_ifetch_unit;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic        clk_i, rst_i;
   logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
   logic [31:0] imem_addr_o, imem_rdata_i;
   logic        redirect_i, stall_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] inst_o, pc_o, pcPlus4_o;
   logic        inst_valid_o;

   ifetch_unit #(
      .RESET_PC (RESET_PC),
      .BUF_DEPTH(BUF_DEPTH),
      .NOP_INST (NOP)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .stall_i      (stall_i),
      .inst_o       (inst_o),
      .pc_o         (pc_o),
      .pcPlus4_o    (pcPlus4_o),
      .inst_valid_o (inst_valid_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // One granted fetch: address, cycle its response becomes due, path epoch.
   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } req_t;

   req_t        mq[$];
   int          cyc, epoch, avail, lat_min, lat_max, grants;
   int          n_tests, n_fail;
   logic [31:0] fetch_exp, exp_pc;
   logic [31:0] m_inst, m_pc, m_pc4;
   logic        m_valid;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input logic rstn, input logic rd, input logic [31:0] rpc,
                       input logic st, input logic g);
      logic        rv, exp_req, req_s;
      logic [31:0] addr_s;
      req_t        r;
      rst_i         = rstn;
      redirect_i    = rd;
      redirect_pc_i = rpc;
      stall_i       = st;
      imem_gnt_i    = g;
      rv            = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? memfn(mq[0].addr) : $urandom;
      #1;
      exp_req = rstn && !rd && ((mq.size() + avail) < BUF_DEPTH);
      check("req", 32'(imem_req_o), 32'(exp_req));
      if (exp_req) check("addr", imem_addr_o, fetch_exp);
      req_s  = imem_req_o;
      addr_s = imem_addr_o;
      @(posedge clk_i);
      #1;
      if (!rstn) begin
         mq.delete();
         avail     = 0;
         fetch_exp = RESET_PC;
         exp_pc    = RESET_PC;
         m_inst    = NOP;
         m_pc      = RESET_PC;
         m_pc4     = RESET_PC + 32'd4;
         m_valid   = 1'b0;
      end else begin
         if (rv) begin
            r = mq.pop_front();
            if (!rd && r.ep == epoch) avail++;
         end
         if (req_s && g) begin
            r.addr = addr_s;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            r.ep   = epoch;
            mq.push_back(r);
            fetch_exp += 32'd4;
            grants++;
         end
         if (rd) begin
            m_inst    = NOP;
            m_valid   = 1'b0;
            epoch++;
            avail     = 0;
            fetch_exp = {rpc[31:2], 2'b00};
            exp_pc    = fetch_exp;
         end else if (!st) begin
            if (avail > 0) begin
               m_inst  = memfn(exp_pc);
               m_pc    = exp_pc;
               m_pc4   = exp_pc + 32'd4;
               m_valid = 1'b1;
               exp_pc += 32'd4;
               avail--;
            end else begin
               m_inst  = NOP;
               m_valid = 1'b0;
            end
         end
      end
      check("inst", inst_o, m_inst);
      check("pc", pc_o, m_pc);
      check("pc4", pcPlus4_o, m_pc4);
      check("valid", 32'(inst_valid_o), 32'(m_valid));
      cyc++;
   endtask

   int          first, cnt, g0, rn;
   logic [31:0] got_pc, tgt;

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; avail = 0; grants = 0;
      lat_min = 1; lat_max = 1;
      fetch_exp = RESET_PC; exp_pc = RESET_PC;
      m_inst = NOP; m_pc = RESET_PC; m_pc4 = RESET_PC + 32'd4; m_valid = 1'b0;
      rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

      repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Streaming from reset with 1-cycle memory
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (first < 0 && inst_valid_o) first = i + 1;
      end
      check("latency", 32'(first), 32'd2);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (inst_valid_o) cnt++;
      end
      check("throughput", 32'(cnt), 32'd8);

      // Stall for 5 cycles mid-stream
      g0 = grants;
      repeat (5) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
      check("stall_fetches", 32'((grants - g0) <= BUF_DEPTH), 32'd1);
      repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

      // Redirect with fetches outstanding (3-cycle memory)
      lat_min = 3; lat_max = 3;
      repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h0000_1002, 1'b0, 1'b1);
      got_pc = '1;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, '0, 1'b0, 1'b1);
         if (inst_valid_o && got_pc == 32'hFFFF_FFFF) got_pc = pc_o;
      end
      check("redir_first_pc", got_pc, 32'h0000_1000);

      // Redirect coinciding with a response while stalled
      lat_min = 1; lat_max = 1;
      repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

      // 3-cycle memory, grant on alternate cycles
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, 1'b0, 1'(i % 2));

      // Address wrap, then reset mid-stream
      lat_min = 1; lat_max = 1;
      step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
      repeat (8) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      repeat (4) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

      // Randomised traffic
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 3000; i++) begin
         rn  = $urandom_range(999, 0);
         tgt = (rn % 2 == 1) ? 32'($urandom) : 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
         step(1'(rn >= 3), 1'(rn >= 3 && rn < 40), tgt,
              1'($urandom_range(4, 0) == 0), 1'($urandom_range(9, 0) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
